// File: rtl/syscall_sequencer.sv
// Multi-cycle syscall service controller: stalls the PC, reads $v0/$a0 through the
// register file's syscall ports, then halts, prints $a0 to the display, or pauses for "go".
module syscall_sequencer #(
  parameter int unsigned HALT_CODE  = 10,
  parameter int unsigned PRINT_CODE = 34,
  parameter int unsigned PAUSE_CODE = 50,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_syscall_req,
  input  logic [31:0]      in_regA,
  input  logic [31:0]      in_regB,
  input  logic             in_go,
  input  logic             in_disp_ready,
  output logic             out_syscall,
  output logic             out_stall,
  output logic             out_halt,
  output logic [31:0]      out_disp,
  output logic             out_disp_valid,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DISPATCH,
    S_WAIT_DISP,
    S_PAUSE,
    S_DONE,
    S_HALT
  } state_t;

  localparam logic [31:0] HALT_V  = 32'(HALT_CODE);
  localparam logic [31:0] PRINT_V = 32'(PRINT_CODE);
  localparam logic [31:0] PAUSE_V = 32'(PAUSE_CODE);

  state_t           state_q, state_d;
  logic [31:0]      v0_q, v0_d;
  logic [31:0]      a0_q, a0_d;
  logic [31:0]      disp_q, disp_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             go_q;
  logic             go_rise;

  // go_q tracks in_go every cycle so a level held across PAUSE entry is not a rise
  assign go_rise = in_go & ~go_q;

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state_q <= S_IDLE;
      v0_q    <= '0;
      a0_q    <= '0;
      disp_q  <= '0;
      count_q <= '0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      v0_q    <= v0_d;
      a0_q    <= a0_d;
      disp_q  <= disp_d;
      count_q <= count_d;
      go_q    <= in_go;
    end
  end

  always_comb begin
    state_d        = state_q;
    v0_d           = v0_q;
    a0_d           = a0_q;
    disp_d         = disp_q;
    count_d        = count_q;
    out_stall      = 1'b1;
    out_syscall    = 1'b0;
    out_halt       = 1'b0;
    out_disp_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        out_stall = in_syscall_req;
        if (in_syscall_req) state_d = S_READ;
      end
      S_READ: begin
        out_syscall = 1'b1;
        v0_d        = in_regA;
        a0_d        = in_regB;
        state_d     = S_DISPATCH;
        if (count_q != '1) count_d = count_q + CNT_W'(1);
      end
      S_DISPATCH: begin
        if (v0_q == HALT_V) begin
          state_d = S_HALT;
        end else if (v0_q == PRINT_V) begin
          state_d = S_WAIT_DISP;
          disp_d  = a0_q;
        end else if (v0_q == PAUSE_V) begin
          state_d = S_PAUSE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_WAIT_DISP: begin
        out_disp_valid = 1'b1;
        if (in_disp_ready) state_d = S_DONE;
      end
      S_PAUSE: begin
        if (go_rise) state_d = S_DONE;
      end
      // Release cycle: the syscall is still on the bus, so the request is ignored here
      S_DONE: begin
        out_stall = 1'b0;
        state_d   = S_IDLE;
      end
      S_HALT: begin
        out_halt = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign out_disp  = disp_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_syscall_sequencer.sv
// Randomized scoreboard bench for syscall_sequencer; a second instance with a 2-bit
// counter shares all inputs so counter saturation is checked alongside normal operation.
module tb_syscall_sequencer;

  localparam logic [31:0] HALT  = 32'd10;
  localparam logic [31:0] PRINT = 32'd34;
  localparam logic [31:0] PAUSE = 32'd50;

  logic        in_clk = 1'b0;
  logic        in_rst_n = 1'b0;
  logic        in_syscall_req = 1'b0;
  logic        in_go = 1'b0;
  logic        in_disp_ready = 1'b0;
  logic [31:0] in_regA, in_regB;
  logic [31:0] cur_v0 = '0;
  logic [31:0] cur_a0 = '0;

  logic        out_syscall, out_stall, out_halt, out_disp_valid;
  logic [31:0] out_disp;
  logic [15:0] out_count;
  logic        s_syscall, s_stall, s_halt, s_valid;
  logic [31:0] s_disp;
  logic [1:0]  s_count;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned n_sys = 0;
  logic [31:0] disp_exp_q[$];
  int unsigned rel_exp_q[$];
  logic [31:0] last_disp_exp = '0;
  logic        rst_at_edge = 1'b0;

  always #5 in_clk = ~in_clk;

  // Register file model: the syscall values only appear while the read ports are forced
  assign in_regA = out_syscall ? cur_v0 : ~cur_v0;
  assign in_regB = out_syscall ? cur_a0 : ({cur_a0[15:0], cur_a0[31:16]} ^ 32'h5A5A_5A5A);

  syscall_sequencer dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_syscall_req(in_syscall_req),
    .in_regA(in_regA), .in_regB(in_regB), .in_go(in_go), .in_disp_ready(in_disp_ready),
    .out_syscall(out_syscall), .out_stall(out_stall), .out_halt(out_halt),
    .out_disp(out_disp), .out_disp_valid(out_disp_valid), .out_count(out_count)
  );

  syscall_sequencer #(.CNT_W(2)) dut_sat (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_syscall_req(in_syscall_req),
    .in_regA(in_regA), .in_regB(in_regB), .in_go(in_go), .in_disp_ready(in_disp_ready),
    .out_syscall(s_syscall), .out_stall(s_stall), .out_halt(s_halt),
    .out_disp(s_disp), .out_disp_valid(s_valid), .out_count(s_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge in_clk) rst_at_edge <= in_rst_n;

  // Monitor: reset state, display transfers and release cycles against the queues
  always @(negedge in_clk) begin
    int unsigned e;
    if (!rst_at_edge) begin
      chk("rst_disp", out_disp, '0);
      chk("rst_count", 32'(out_count), '0);
      chk("rst_count_sat", 32'(s_count), '0);
      chk("rst_halt", 32'(out_halt), '0);
      chk("rst_valid", 32'(out_disp_valid), '0);
      chk("rst_syscall", 32'(out_syscall), '0);
      chk("rst_stall", 32'(out_stall), 32'(in_syscall_req));
      disp_exp_q.delete();
      rel_exp_q.delete();
      last_disp_exp = '0;
    end else begin
      if (out_disp_valid) begin
        if (disp_exp_q.size() == 0) begin
          chk("disp_unexpected", 32'(out_disp_valid), '0);
        end else begin
          chk("disp_stable", out_disp, disp_exp_q[0]);
          if (in_disp_ready) last_disp_exp = disp_exp_q.pop_front();
        end
      end else begin
        chk("disp_hold", out_disp, last_disp_exp);
      end
      if (in_syscall_req && !out_stall) begin
        if (rel_exp_q.size() == 0) begin
          chk("release_unexpected", 32'(out_stall), 32'd1);
        end else begin
          e = rel_exp_q.pop_front();
          chk("count", 32'(out_count), e);
          chk("count_sat", 32'(s_count), (e > 3) ? 32'd3 : e);
        end
      end
    end
  end

  // One syscall from its IDLE request cycle (c=0) through release (or halt entry)
  task automatic do_syscall(input logic [31:0] v0, input logic [31:0] a0,
                            input int unsigned k, input bit go_pre);
    bit is_pr, is_pa, is_h;
    int unsigned rel;
    is_pr = (v0 == PRINT);
    is_pa = (v0 == PAUSE);
    is_h  = (v0 == HALT);
    rel   = is_h ? 3 : is_pr ? 4 + k : is_pa ? 8 : 3;
    @(posedge in_clk); #1;
    cur_v0 = v0;
    cur_a0 = a0;
    in_syscall_req = 1'b1;
    n_sys++;
    if (is_pr) disp_exp_q.push_back(a0);
    if (!is_h) rel_exp_q.push_back(n_sys);
    for (int unsigned c = 0; c <= rel; c++) begin
      if (c > 0) begin @(posedge in_clk); #1; end
      in_disp_ready = (k == 0) ? 1'b1 : (c >= 3 + k);
      if (is_pa) in_go = (c >= 7) || (go_pre ? (c < 5) : (c == 1));
      else       in_go = 1'($urandom_range(0, 1));
      @(negedge in_clk);
      chk("stall", 32'(out_stall), 32'(is_h || (c < rel)));
      chk("syscall", 32'(out_syscall), 32'(c == 1));
      chk("halt", 32'(out_halt), 32'(is_h && (c >= 3)));
      chk("valid", 32'(out_disp_valid), 32'(is_pr && (c >= 3) && (c < rel)));
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge in_clk); #1;
      in_syscall_req = 1'b0;
      @(negedge in_clk);
      chk("idle_stall", 32'(out_stall), '0);
    end
  endtask

  task automatic do_reset(input int unsigned n);
    @(posedge in_clk); #1;
    in_rst_n = 1'b0;
    in_syscall_req = 1'b0;
    repeat (n) @(posedge in_clk);
    #1;
    in_rst_n = 1'b1;
    n_sys = 0;
  endtask

  initial begin
    logic [31:0] v;
    int unsigned sel;
    repeat (2) @(posedge in_clk);
    #1;
    in_rst_n = 1'b1;
    idle(2);

    do_syscall(32'd5, $urandom, 0, 1'b0);
    idle(1);
    for (int i = 0; i < 5; i++) do_syscall(32'd0, $urandom, 0, 1'b0);
    idle(1);
    do_syscall(PRINT, 32'hDEAD_BEEF, 4, 1'b0);
    idle(2);
    do_syscall(PAUSE, $urandom, 0, 1'b1);
    do_syscall(PAUSE, $urandom, 2, 1'b0);
    do_syscall(PRINT | 32'h0000_0100, $urandom, 0, 1'b0);
    do_syscall(HALT | 32'h8000_0000, $urandom, 0, 1'b0);
    do_syscall(PRINT, $urandom, 0, 1'b0);
    idle(1);

    // Reset while the display handshake is pending
    @(posedge in_clk); #1;
    cur_v0 = PRINT;
    cur_a0 = 32'h1234_5678;
    in_disp_ready = 1'b0;
    in_syscall_req = 1'b1;
    n_sys++;
    disp_exp_q.push_back(cur_a0);
    repeat (5) @(posedge in_clk);
    @(negedge in_clk);
    chk("mid_valid", 32'(out_disp_valid), 32'd1);
    do_reset(1);
    idle(2);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: v = PRINT;
        1: v = PAUSE;
        2: begin
          v = $urandom;
          if (v == HALT || v == PRINT || v == PAUSE) v = 32'd7;
        end
        default: v = PRINT ^ (32'd1 << $urandom_range(6, 31));
      endcase
      do_syscall(v, $urandom, $urandom_range(0, 5), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

    do_syscall(HALT, $urandom, 0, 1'b0);
    repeat (100) begin
      @(posedge in_clk); #1;
      in_syscall_req = 1'($urandom_range(0, 1));
      @(negedge in_clk);
      chk("halt_hold", 32'(out_halt), 32'd1);
      chk("halt_stall", 32'(out_stall), 32'd1);
    end
    do_reset(1);
    idle(2);
    do_syscall(PRINT, 32'hCAFE_F00D, 1, 1'b0);
    idle(2);

    chk("queues_drained", disp_exp_q.size() + rel_exp_q.size(), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
